// File: rtl/button_debouncer_if.sv
// Button-side signal bundle for the debouncer: raw input, debounced level,
// edge strobes, busy flag and an FSM state tap.
interface button_debouncer_if;
    logic       btn_in;
    logic       btn_level;
    logic       rise_evt;
    logic       fall_evt;
    logic       busy;
    logic [1:0] dbg_state;

    // btn_in is a plain asynchronous level; the outputs are registered levels/strobes
    // with no valid/ready handshake: rise_evt/fall_evt are single-cycle strobes.
    modport master (
        output btn_in,
        input  btn_level,
        input  rise_evt,
        input  fall_evt,
        input  busy,
        input  dbg_state
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output rise_evt,
        output fall_evt,
        output busy,
        output dbg_state
    );
endinterface

// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-flop synchronizer, stability counter and a 4-state
// FSM producing a clean level, one-cycle rise/fall strobes and a busy flag.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter bit ACTIVE_LOW_BTN  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    button_debouncer_if.slave bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_WAIT = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_WAIT = 2'd3
    } state_t;

    logic             w_b;
    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             r_busy;
    logic             w_level_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;
    logic             w_busy_nxt;

    // Normalise polarity before synchronizing so the FSM always sees 1 = pressed.
    assign w_b = bus.btn_in ^ ACTIVE_LOW_BTN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= w_b;
            r_s2 <= r_s1;
        end
    end

    // State register, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // A reversion is tested before terminal count, so it wins on that cycle too.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            ST_LOW: begin
                if (r_s2) w_state_nxt = ST_RISE_WAIT;
            end
            ST_RISE_WAIT: begin
                if (!r_s2)                  w_state_nxt = ST_LOW;
                else if (r_cnt == CNT_LAST) w_state_nxt = ST_HIGH;
                else                        w_cnt_nxt   = r_cnt + CNT_ONE;
            end
            ST_HIGH: begin
                if (!r_s2) w_state_nxt = ST_FALL_WAIT;
            end
            ST_FALL_WAIT: begin
                if (r_s2)                   w_state_nxt = ST_HIGH;
                else if (r_cnt == CNT_LAST) w_state_nxt = ST_LOW;
                else                        w_cnt_nxt   = r_cnt + CNT_ONE;
            end
            default: begin
                w_state_nxt = ST_LOW;
            end
        endcase
    end

    always_comb begin
        w_level_nxt = (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_FALL_WAIT);
        w_rise_nxt  = (r_state == ST_RISE_WAIT) && (w_state_nxt == ST_HIGH);
        w_fall_nxt  = (r_state == ST_FALL_WAIT) && (w_state_nxt == ST_LOW);
        w_busy_nxt  = (w_state_nxt == ST_RISE_WAIT) || (w_state_nxt == ST_FALL_WAIT);
    end

    assign bus.btn_level = r_level;
    assign bus.rise_evt  = r_rise;
    assign bus.fall_evt  = r_fall;
    assign bus.busy      = r_busy;
    assign bus.dbg_state = r_state;

    a_evt_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_rise && r_fall));
    a_busy_matches_state: assert property (@(posedge clk) disable iff (!rst_n)
        r_busy == ((r_state == ST_RISE_WAIT) || (r_state == ST_FALL_WAIT)));
    a_cnt_idle_zero: assert property (@(posedge clk) disable iff (!rst_n)
        ((r_state == ST_LOW) || (r_state == ST_HIGH)) |-> (r_cnt == '0));
    a_cnt_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        r_cnt <= CNT_LAST);
endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed table, hand-written corner sequences and
// random bouncing checked against a run-length reference model.
module tb_button_debouncer;
    localparam int D   = 8;
    localparam int LAT = D + 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    button_debouncer_if hi_if ();
    button_debouncer_if lo_if ();

    button_debouncer #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW_BTN(1'b0)) dut_hi (
        .clk(clk), .rst_n(rst_n), .bus(hi_if.slave));
    button_debouncer #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW_BTN(1'b1)) dut_lo (
        .clk(clk), .rst_n(rst_n), .bus(lo_if.slave));

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit btn;
        bit exp_level;
        bit exp_rise;
        bit exp_fall;
        bit exp_busy;
    } vec_t;
    vec_t tbl[20];

    // Reference model: b is seen by the FSM two samples late; the level flips once
    // D+1 consecutive delayed samples disagree with it.
    bit m_d1, m_d2, m_level, m_rise, m_fall, m_busy;
    int m_run;

    task automatic model_reset();
        m_d1 = 0; m_d2 = 0; m_level = 0; m_rise = 0; m_fall = 0; m_busy = 0; m_run = 0;
    endtask

    task automatic model_edge(input bit b);
        bit seen;
        seen = m_d2;
        m_rise = 0;
        m_fall = 0;
        m_run = (seen != m_level) ? m_run + 1 : 0;
        if (m_run == D + 1) begin
            m_level = seen;
            m_rise = seen;
            m_fall = !seen;
            m_run = 0;
        end
        m_busy = (m_run != 0);
        m_d2 = m_d1;
        m_d1 = b;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("model_level", hi_if.btn_level, m_level);
        chk("model_rise", hi_if.rise_evt, m_rise);
        chk("model_fall", hi_if.fall_evt, m_fall);
        chk("model_busy", hi_if.busy, m_busy);
    endtask

    task automatic tick(input bit b);
        hi_if.btn_in = b;
        @(posedge clk);
        if (rst_n) model_edge(b);
        else model_reset();
        #1;
        chk_model();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hi_level"}, hi_if.btn_level, 0);
        chk({tag, "_hi_rise"}, hi_if.rise_evt, 0);
        chk({tag, "_hi_fall"}, hi_if.fall_evt, 0);
        chk({tag, "_hi_busy"}, hi_if.busy, 0);
        chk({tag, "_hi_state"}, hi_if.dbg_state, 0);
        chk({tag, "_lo_level"}, lo_if.btn_level, 0);
        chk({tag, "_lo_rise"}, lo_if.rise_evt, 0);
        chk({tag, "_lo_busy"}, lo_if.busy, 0);
    endtask

    initial begin
        int rises, falls, busy_seen, run_len;
        bit cur, b;

        hi_if.btn_in = 0;
        lo_if.btn_in = 1;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            tbl[i].btn       = 1;
            tbl[i].exp_level = (i + 1) >= LAT;
            tbl[i].exp_rise  = (i + 1) == LAT;
            tbl[i].exp_fall  = 0;
            tbl[i].exp_busy  = ((i + 1) >= 3) && ((i + 1) <= LAT - 1);
        end

        #2;
        chk_all_zero("reset");
        #10 rst_n = 1;
        for (int i = 0; i < 4; i++) tick(0);

        // Clean press from the table.
        for (int i = 0; i < 20; i++) begin
            tick(tbl[i].btn);
            chk("press_level", hi_if.btn_level, tbl[i].exp_level);
            chk("press_rise", hi_if.rise_evt, tbl[i].exp_rise);
            chk("press_fall", hi_if.fall_evt, tbl[i].exp_fall);
            chk("press_busy", hi_if.busy, tbl[i].exp_busy);
        end

        // Glitch while HIGH.
        falls = 0; busy_seen = 0;
        for (int j = 0; j < 20; j++) begin
            tick(j < 5 ? 1'b0 : 1'b1);
            if (hi_if.fall_evt) falls++;
            if (hi_if.busy) busy_seen++;
            if (hi_if.btn_level !== 1'b1) chk("glitch_level", hi_if.btn_level, 1);
        end
        chk("glitch_falls", falls, 0);
        chk("glitch_busy_seen", busy_seen > 0, 1);
        chk("glitch_busy_clear", hi_if.busy, 0);
        chk("glitch_level_end", hi_if.btn_level, 1);

        // Release.
        falls = 0;
        for (int e = 1; e <= 20; e++) begin
            tick(0);
            if (hi_if.fall_evt) falls++;
            if (e == LAT - 1) chk("release_level_before", hi_if.btn_level, 1);
            if (e == LAT) begin
                chk("release_level", hi_if.btn_level, 0);
                chk("release_fall", hi_if.fall_evt, 1);
            end
        end
        chk("release_fall_count", falls, 1);

        // Reversion on the terminal-count cycle: exactly D ones is rejected.
        rises = 0;
        for (int j = 0; j < D + 14; j++) begin
            tick(j < D ? 1'b1 : 1'b0);
            if (hi_if.rise_evt) rises++;
        end
        chk("terminal_reject_rises", rises, 0);
        chk("terminal_reject_level", hi_if.btn_level, 0);

        // D+1 ones is just enough to be accepted.
        rises = 0;
        for (int e = 1; e <= D + 1 + 24; e++) begin
            tick(e <= D + 1 ? 1'b1 : 1'b0);
            if (hi_if.rise_evt) rises++;
            if (e == LAT) chk("terminal_accept_rise", hi_if.rise_evt, 1);
        end
        chk("terminal_accept_rises", rises, 1);
        chk("terminal_accept_back_low", hi_if.btn_level, 0);

        // Bounce: toggle every 3 cycles for 15 cycles, then hold 1.
        rises = 0;
        for (int j = 1; j <= 26; j++) begin
            tick(j <= 15 ? (((j - 1) / 3) % 2 == 0) : 1'b1);
            if (j <= 15 && hi_if.rise_evt) rises++;
            if (j - 12 == LAT - 1) chk("bounce_level_before", hi_if.btn_level, 0);
            if (j - 12 == LAT) begin
                chk("bounce_level", hi_if.btn_level, 1);
                chk("bounce_rise", hi_if.rise_evt, 1);
            end
        end
        chk("bounce_rises_during_toggle", rises, 0);
        for (int j = 0; j < 20; j++) tick(0);

        // Reset mid-wait with cnt=4 (edge 7 of a press).
        for (int e = 1; e <= 7; e++) tick(1);
        chk("midwait_busy", hi_if.busy, 1);
        rst_n = 0;
        model_reset();
        #1;
        chk_all_zero("async_reset");
        #2 rst_n = 1;
        for (int e = 1; e <= 14; e++) begin
            tick(1);
            if (e == LAT - 1) chk("after_reset_level_before", hi_if.btn_level, 0);
            if (e == LAT) chk("after_reset_level", hi_if.btn_level, 1);
        end

        // Random bouncing against the model.
        cur = 1;
        run_len = 0;
        for (int j = 0; j < 400; j++) begin
            if (run_len == 0) begin
                cur = !cur;
                run_len = $urandom_range(1, 13);
            end
            run_len--;
            b = cur;
            tick(b);
            chk("rand_state_busy", hi_if.busy, hi_if.dbg_state[0]);
        end
        for (int j = 0; j < 30; j++) tick(1);
        rises = 0;
        for (int j = 0; j < 40; j++) begin
            tick(1);
            if (hi_if.rise_evt || hi_if.fall_evt) rises++;
        end
        chk("steady_no_events", rises, 0);

        // Active-low input on the second instance.
        rst_n = 0;
        model_reset();
        lo_if.btn_in = 1;
        tick(0);
        tick(0);
        #2 rst_n = 1;
        for (int j = 0; j < 3; j++) tick(0);
        chk("lo_idle_level", lo_if.btn_level, 0);
        chk("lo_idle_busy", lo_if.busy, 0);
        lo_if.btn_in = 0;
        rises = 0;
        for (int e = 1; e <= 20; e++) begin
            tick(0);
            if (lo_if.rise_evt) rises++;
            chk("lo_level", lo_if.btn_level, e >= LAT);
            chk("lo_rise", lo_if.rise_evt, e == LAT);
        end
        chk("lo_rise_count", rises, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
